// File: rtl/pcd8544_spi_tx_if.sv
// Sequencer-side handshake between the display sequencer and the PCD8544 byte serializer.
// The sequencer presents a byte plus D/C level and holds start; the serializer strobes avail on capture.
interface pcd8544_spi_tx_if #(
    parameter int DIV_W = 16
);
    logic [7:0]       data;
    logic             command;
    logic             start;
    logic [DIV_W-1:0] div_factor;
    logic             busy;
    logic             avail;

    modport master (
        output data,
        output command,
        output start,
        output div_factor,
        input  busy,
        input  avail
    );

    modport slave (
        input  data,
        input  command,
        input  start,
        input  div_factor,
        output busy,
        output avail
    );
endinterface

// File: rtl/pcd8544_spi_tx.sv
// PCD8544 (Nokia 5110) byte serializer: LCD power-up reset pulse, then MSB-first SPI mode 0
// bytes with D/C and SCE, one avail strobe per accepted byte.
//
// state    | meaning
// RST_HOLD | LCD rst held low for RST_CYCLES clocks after reset release
// IDLE     | sce high, waiting for start
// LOAD     | capture byte, D/C and half-period; avail high
// SHIFT_LO | sclk low for half clocks, mosi holds current bit
// SHIFT_HI | sclk high for half clocks; LCD has sampled mosi on the rise
module pcd8544_spi_tx #(
    parameter int DIV_W      = 16,
    parameter int RST_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    pcd8544_spi_tx_if.slave    seq,
    output logic               sclk_o,
    output logic               mosi_o,
    output logic               sce_o,
    output logic               dc_o,
    output logic               lcd_rst_o
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI
    } state_t;

    state_t           state_q;
    logic [RST_W-1:0] rst_cnt_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] half_q;
    logic [DIV_W-1:0] half_d;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shreg_q;
    logic             sclk_q;
    logic             mosi_q;
    logic             sce_q;
    logic             dc_q;
    logic             lcd_rst_q;
    logic             busy_q;
    logic             avail_q;

    // A zero divider would underflow the down-counter, so it is clamped to one clock.
    always_comb begin
        half_d = (seq.div_factor == '0) ? DIV_W'(1) : seq.div_factor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_HOLD;
            rst_cnt_q <= RST_W'(RST_CYCLES - 1);
            div_cnt_q <= '0;
            half_q    <= DIV_W'(1);
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            sce_q     <= 1'b1;
            dc_q      <= 1'b0;
            lcd_rst_q <= 1'b0;
            busy_q    <= 1'b1;
            avail_q   <= 1'b0;
        end else begin
            avail_q <= 1'b0;
            case (state_q)
                RST_HOLD: begin
                    if (rst_cnt_q == '0) begin
                        lcd_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - RST_W'(1);
                    end
                end
                IDLE: begin
                    if (seq.start) begin
                        busy_q  <= 1'b1;
                        avail_q <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    shreg_q   <= seq.data;
                    dc_q      <= seq.command;
                    half_q    <= half_d;
                    div_cnt_q <= half_d - DIV_W'(1);
                    mosi_q    <= seq.data[7];
                    sce_q     <= 1'b0;
                    bit_cnt_q <= 3'd7;
                    state_q   <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (div_cnt_q == '0) begin
                        sclk_q    <= 1'b1;
                        div_cnt_q <= half_q - DIV_W'(1);
                        state_q   <= SHIFT_HI;
                    end else begin
                        div_cnt_q <= div_cnt_q - DIV_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt_q == '0) begin
                        sclk_q    <= 1'b0;
                        div_cnt_q <= half_q - DIV_W'(1);
                        if (bit_cnt_q != 3'd0) begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                            shreg_q   <= {shreg_q[6:0], 1'b0};
                            mosi_q    <= shreg_q[6];
                            state_q   <= SHIFT_LO;
                        end else if (seq.start) begin
                            // Back-to-back byte: sce stays low across the boundary.
                            avail_q <= 1'b1;
                            state_q <= LOAD;
                        end else begin
                            sce_q   <= 1'b1;
                            mosi_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q - DIV_W'(1);
                    end
                end
                default: begin
                    sce_q   <= 1'b1;
                    sclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign sce_o     = sce_q;
    assign dc_o      = dc_q;
    assign lcd_rst_o = lcd_rst_q;
    assign seq.busy  = busy_q;
    assign seq.avail = avail_q;

endmodule

// File: tb/tb_pcd8544_spi_tx.sv
// Randomized bench for pcd8544_spi_tx: a frame-level model records each accepted byte and
// checks what appears on the LCD pins, phase lengths and byte spacing.
module tb_pcd8544_spi_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sclk, mosi, sce, dc, lcd_rst;

    always #5 clk = ~clk;

    pcd8544_spi_tx_if #(.DIV_W(16)) seq_if ();

    pcd8544_spi_tx #(.DIV_W(16), .RST_CYCLES(1000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seq       (seq_if.slave),
        .sclk_o    (sclk),
        .mosi_o    (mosi),
        .sce_o     (sce),
        .dc_o      (dc),
        .lcd_rst_o (lcd_rst)
    );

    typedef struct {
        logic [7:0] b;
        logic       c;
        int         half;
    } frame_t;

    frame_t     exp_q[$];
    int         tests = 0;
    int         errs = 0;
    int         cyc = 0;
    int         mon_nb = 0;
    int         mon_run = 0;
    int         cur_half = 1;
    int         bytes_done = 0;
    int         avail_cnt = 0;
    int         hold_avail = 0;
    int         sent = 0;
    logic [7:0] mon_bits = 8'h00;
    logic       prev_sclk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int half_of(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    // Pin-level monitor: rebuilds bytes from mosi at each sclk rise and compares to accepted frames.
    always @(negedge clk) begin
        frame_t f;
        if (!rst_n) begin
            exp_q.delete();
            mon_nb    = 0;
            mon_run   = 0;
            prev_sclk = 1'b0;
        end else begin
            if (sclk !== prev_sclk) begin
                if (sclk) begin
                    if (mon_nb > 0) chk_val("low_phase", mon_run, cur_half);
                    chk_val("sce_on_rise", {31'd0, sce}, 32'd0);
                    mon_bits = {mon_bits[6:0], mosi};
                    mon_nb++;
                    if (mon_nb == 8) begin
                        if (exp_q.size() == 0) begin
                            chk_val("unexpected_byte", 32'd1, 32'd0);
                        end else begin
                            f = exp_q.pop_front();
                            chk_val("byte", {24'd0, mon_bits}, {24'd0, f.b});
                            chk_val("dc", {31'd0, dc}, {31'd0, f.c});
                            bytes_done++;
                        end
                        mon_nb = 0;
                    end
                end else begin
                    chk_val("high_phase", mon_run, cur_half);
                end
                mon_run = 1;
            end else begin
                mon_run++;
            end
            prev_sclk = sclk;
            if (avail) begin
                avail_cnt++;
                if (!lcd_rst) hold_avail++;
                f.b      = seq_if.data;
                f.c      = seq_if.command;
                f.half   = half_of(seq_if.div_factor);
                cur_half = f.half;
                exp_q.push_back(f);
            end
        end
    end

    task automatic drive(input logic [7:0] b, input logic c, input logic [15:0] d);
        seq_if.data       = b;
        seq_if.command    = c;
        seq_if.div_factor = d;
    endtask

    task automatic wait_avail(output int n, output int sce_hi);
        n = 0;
        sce_hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (sce) sce_hi++;
        end while (!avail && n < 2000);
        if (!avail) chk_val("avail_timeout", 32'd0, 32'd1);
        else sent++;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((seq_if.busy || !sce) && n < 2000);
        chk_val("idle_reached", {31'd0, seq_if.busy}, 32'd0);
    endtask

    task automatic count_rst_low(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (lcd_rst || n >= 1500) break;
            n++;
        end
    endtask

    task automatic check_reset_pins();
        chk_val("rst_lcd_rst", {31'd0, lcd_rst}, 32'd0);
        chk_val("rst_sce", {31'd0, sce}, 32'd1);
        chk_val("rst_sclk", {31'd0, sclk}, 32'd0);
        chk_val("rst_mosi", {31'd0, mosi}, 32'd0);
        chk_val("rst_dc", {31'd0, dc}, 32'd0);
        chk_val("rst_busy", {31'd0, seq_if.busy}, 32'd1);
        chk_val("rst_avail", {31'd0, seq_if.avail}, 32'd0);
    endtask

    wire avail = seq_if.avail;

    initial begin
        int n, h, a0, b0, len, prev_half;
        logic [7:0] stream [4];
        stream = '{8'h21, 8'h90, 8'h20, 8'h0C};
        seq_if.start = 1'b0;
        drive(8'h00, 1'b0, 16'd2);

        #1 rst_n = 1'b0;
        #1 check_reset_pins();
        @(posedge clk);
        #2 rst_n = 1'b1;
        count_rst_low(n);
        chk_val("rst_low_clocks", n, 1000);
        chk_val("post_hold_busy", {31'd0, seq_if.busy}, 32'd0);
        chk_val("post_hold_sce", {31'd0, sce}, 32'd1);

        // single 0x21 command byte at div 2
        @(posedge clk);
        #2 drive(8'h21, 1'b0, 16'd2);
        seq_if.start = 1'b1;
        a0 = avail_cnt;
        b0 = bytes_done;
        wait_avail(n, h);
        @(posedge clk);
        #2 seq_if.start = 1'b0;
        wait_idle();
        chk_val("single_avails", avail_cnt - a0, 1);
        chk_val("single_bytes", bytes_done - b0, 1);
        chk_val("single_dc", {31'd0, dc}, 32'd0);

        // back-to-back stream with start held
        @(posedge clk);
        #2 drive(stream[0], 1'b0, 16'd2);
        seq_if.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_avail(n, h);
            if (i > 0) begin
                chk_val("stream_gap", n, 33);
                chk_val("stream_sce_low", h, 0);
            end
            @(posedge clk);
            #2;
            if (i < 3) drive(stream[i+1], 1'b0, 16'd2);
            else seq_if.start = 1'b0;
        end
        h = 0;
        repeat (32) begin
            @(negedge clk);
            if (sce) h++;
        end
        chk_val("stream_tail_sce_low", h, 0);
        @(negedge clk);
        chk_val("stream_end_sce", {31'd0, sce}, 32'd1);
        wait_idle();

        // start dropped 3 clocks after avail
        @(posedge clk);
        #2 drive(8'hFF, 1'b1, 16'd2);
        seq_if.start = 1'b1;
        b0 = bytes_done;
        wait_avail(n, h);
        repeat (3) @(posedge clk);
        #2 seq_if.start = 1'b0;
        wait_idle();
        chk_val("drop_bytes", bytes_done - b0, 1);
        chk_val("drop_sce", {31'd0, sce}, 32'd1);
        chk_val("drop_mosi", {31'd0, mosi}, 32'd0);

        // div_factor 0 behaves as 1
        @(posedge clk);
        #2 drive(8'hA5, 1'b1, 16'd0);
        seq_if.start = 1'b1;
        wait_avail(n, h);
        @(posedge clk);
        #2 seq_if.start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sce && n < 100);
        chk_val("div0_byte_clocks", n, 17);
        wait_idle();

        // random bursts
        for (int it = 0; it < 12; it++) begin
            len = int'($urandom_range(1, 4));
            @(posedge clk);
            #2 drive(8'($urandom), 1'($urandom), 16'($urandom_range(0, 4)));
            seq_if.start = 1'b1;
            prev_half = 1;
            for (int j = 0; j < len; j++) begin
                wait_avail(n, h);
                if (j > 0) chk_val("rnd_gap", n, 16 * prev_half + 1);
                prev_half = half_of(seq_if.div_factor);
                @(posedge clk);
                #2;
                if (j < len - 1) drive(8'($urandom), 1'($urandom), 16'($urandom_range(0, 4)));
                else seq_if.start = 1'b0;
            end
            wait_idle();
        end

        // reset in the middle of a byte
        @(posedge clk);
        #2 drive(8'($urandom), 1'b1, 16'd2);
        seq_if.start = 1'b1;
        wait_avail(n, h);
        sent--;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mon_nb != 4 && n < 200);
        #3 rst_n = 1'b0;
        #1 check_reset_pins();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        count_rst_low(n);
        chk_val("rerst_low_clocks", n, 1000);
        chk_val("hold_avails", hold_avail, 0);
        wait_avail(n, h);
        @(posedge clk);
        #2 seq_if.start = 1'b0;
        wait_idle();

        chk_val("queue_drained", exp_q.size(), 0);
        chk_val("bytes_total", bytes_done, sent);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d errs=%0d)", tests, errs);
        $fatal(1, "watchdog");
    end

endmodule
